piso_frame_ctrl: RTL

- Sequencer that feeds a parallel-in/serial-out shifter configured for fast mode, MSB-first.
  - In fast mode the first bit of a word appears in the same cycle the word is loaded.
- Pulls words from an upstream valid/ready stream and issues one load per word.
- Counts the DATA_WIDTH bit slots of each word and frames a burst of N words with a frame strobe and a configurable inter-frame gap.
- Sits between a word FIFO/DMA and the serial shifter of a link transmitter.

---
 rtl/piso_frame_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/piso_frame_ctrl.sv
// Frame sequencer for a fast-mode MSB-first PISO shifter.
// Pulls words from a valid/ready stream, counts bit slots, frames N words.
module piso_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_s_rst,
    input  logic                  i_start,
    input  logic [LEN_WIDTH-1:0]  i_len,
    input  logic                  i_abort,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    output logic                  o_piso_wr_en,
    output logic [DATA_WIDTH-1:0] o_piso_data,
    output logic                  o_bit_valid,
    output logic                  o_frame,
    output logic                  o_busy,
    output logic                  o_underrun,
    output logic                  o_done
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BIT_INIT = BW'(DATA_WIDTH - 1);
    localparam logic [GW-1:0] GAP_INIT =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
    logic                 done_q, done_d;
    logic                 kill;
    logic                 last_word;

    // Reset mid-frame behaves exactly like abort for the handshake.
    assign kill      = i_abort | i_s_rst;
    assign last_word = (word_cnt_q == len_q);
    assign o_done    = done_q;

    always_ff @(posedge i_clk) begin
        if (i_s_rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_cnt_d   = word_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        done_d       = 1'b0;
        o_s_ready    = 1'b0;
        o_piso_wr_en = 1'b0;
        o_piso_data  = '0;
        o_bit_valid  = 1'b0;
        o_frame      = 1'b0;
        o_underrun   = 1'b0;
        o_busy       = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    len_d      = i_len;
                    word_cnt_d = '0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                o_frame    = 1'b1;
                o_underrun = !i_s_valid && (word_cnt_q != '0);
                if (!kill) begin
                    o_s_ready = 1'b1;
                    if (i_s_valid) begin
                        o_piso_wr_en = 1'b1;
                        o_piso_data  = i_s_data;
                        o_bit_valid  = 1'b1;
                        bit_cnt_d    = BIT_INIT;
                        state_d      = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                o_frame     = 1'b1;
                o_bit_valid = !kill;
                bit_cnt_d   = bit_cnt_q - BW'(1);
                if (bit_cnt_q == BW'(1)) begin
                    if (!last_word) begin
                        word_cnt_d = word_cnt_q + LEN_WIDTH'(1);
                        state_d    = S_LOAD;
                    end else if (GAP_CYCLES == 0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        gap_cnt_d = GAP_INIT;
                        state_d   = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (kill) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

endmodule
